// File: rtl/norm_unit_if.sv
// Request/result bundle for norm_unit (iterative CLZ/CLS normalizer).
// Handshake: start is a one-cycle request taken only when busy=0; done is a
// one-cycle pulse and out/sh/zero are valid from that cycle until the next done.
interface norm_unit_if #(
  parameter int WIDTH = 32,
  parameter int SH_W  = 5
);
  logic             start;
  logic             mode;
  logic [WIDTH-1:0] in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out;
  logic [SH_W-1:0]  sh;
  logic             zero;

  modport master (
    output start, mode, in,
    input  busy, done, out, sh, zero
  );

  modport slave (
    input  start, mode, in,
    output busy, done, out, sh, zero
  );
endinterface

// File: rtl/norm_unit.sv
// Iterative normalizer: finds the left shift that normalizes an operand (CLZ or CLS).
// Optional NORM_FAST_EN adds a 4-bit coarse step per cycle; results are unchanged.
module norm_unit #(
  parameter int WIDTH = 32,
  parameter int SH_W  = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  norm_unit_if.slave nif,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [SH_W-1:0] C_MAX = SH_W'(WIDTH - 1);
`ifdef NORM_FAST_EN
  localparam logic [SH_W-1:0] C_FAST_MAX = SH_W'(WIDTH - 5);
`endif

  state_t           state;
  logic [WIDTH-1:0] w;
  logic [SH_W-1:0]  c;
  logic             mode_q;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] out_r;
  logic [SH_W-1:0]  sh_r;
  logic             zero_r;

  logic w_zero;
  logic norm_hit;
  logic stop;
`ifdef NORM_FAST_EN
  logic coarse;
`endif

  always_comb begin
    w_zero   = (w == '0);
    norm_hit = mode_q ? (w[WIDTH-1] ^ w[WIDTH-2]) : w[WIDTH-1];
    stop     = w_zero | (c == C_MAX) | norm_hit;
`ifdef NORM_FAST_EN
    // Coarse step only when at least four more shifts are certain to follow.
    coarse = 1'b0;
    if (c <= C_FAST_MAX) begin
      if (mode_q)
        coarse = (w[WIDTH-1:WIDTH-5] == '0) || (w[WIDTH-1:WIDTH-5] == '1);
      else
        coarse = (w[WIDTH-1:WIDTH-4] == '0);
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      w      <= '0;
      c      <= '0;
      mode_q <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      out_r  <= '0;
      sh_r   <= '0;
      zero_r <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done_r <= 1'b0;
          // DONE accepts a new request exactly like IDLE, so back-to-back has no bubble.
          if (nif.start) begin
            w      <= nif.in;
            c      <= '0;
            mode_q <= nif.mode;
            busy_r <= 1'b1;
            state  <= SHIFT;
          end else begin
            state  <= IDLE;
          end
        end
        SHIFT: begin
          if (stop) begin
            out_r  <= w;
            sh_r   <= c;
            zero_r <= w_zero;
            busy_r <= 1'b0;
            done_r <= 1'b1;
            state  <= DONE;
`ifdef NORM_FAST_EN
          end else if (coarse) begin
            w <= w << 4;
            c <= c + SH_W'(4);
`endif
          end else begin
            w <= w << 1;
            c <= c + SH_W'(1);
          end
        end
        default: begin
          busy_r <= 1'b0;
          done_r <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign nif.busy  = busy_r;
  assign nif.done  = done_r;
  assign nif.out   = out_r;
  assign nif.sh    = sh_r;
  assign nif.zero  = zero_r;
  assign state_dbg = state;

endmodule

// File: tb/tb_norm_unit.sv
// Bench for norm_unit: directed and random operands, scoreboard checked against a
// leading-bit-count reference model, including latency, busy, back-to-back and reset abort.
module tb_norm_unit;

  logic       clk;
  logic       rst_n;
  logic [1:0] state_dbg;

  norm_unit_if #(.WIDTH(32), .SH_W(5)) nif ();

  norm_unit #(.WIDTH(32), .SH_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .nif       (nif),
    .state_dbg (state_dbg)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  bit checking = 1'b0;
  int free_cyc = 0;

  logic [37:0] exp_q[$];     // {zero, sh, out}
  int          acc_cyc_q[$];
  int          exp_cyc_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // reference model: count leading zeros / redundant sign bits directly
  function automatic logic [37:0] ref_norm(input logic m, input logic [31:0] v);
    int s;
    logic [31:0] o;
    s = 0;
    if (v != 0) begin
      if (!m) begin
        for (int i = 31; i >= 0; i--)
          if (v[i]) begin s = 31 - i; break; end
      end else begin
        s = 31;
        for (int i = 30; i >= 0; i--)
          if (v[i] != v[31]) begin s = 30 - i; break; end
      end
    end
    o = v << s;
    return {(v == 0), 5'(s), o};
  endfunction

  function automatic int ref_lat(input int s);
`ifdef NORM_FAST_EN
    int k;
    k = s / 4;
    if (k > 7) k = 7;
    return k + (s - 4 * k) + 2;
`else
    return s + 2;
`endif
  endfunction

  // driver tasks (called at a negedge)
  task automatic issue(input logic m, input logic [31:0] v, input bit accept);
    logic [37:0] e;
    int lat;
    nif.start = 1'b1;
    nif.mode  = m;
    nif.in    = v;
    if (accept) begin
      e   = ref_norm(m, v);
      lat = ref_lat(int'(e[36:32]));
      exp_q.push_back(e);
      acc_cyc_q.push_back(cyc + 1);
      exp_cyc_q.push_back(cyc + lat);
      free_cyc = cyc + lat;
    end
    @(negedge clk);
    nif.start = 1'b0;
    nif.in    = $urandom;
  endtask

  task automatic wait_free(input int gap);
    while (cyc < free_cyc + gap) @(negedge clk);
  endtask

  task automatic op(input logic m, input logic [31:0] v, input int gap);
    wait_free(gap);
    issue(m, v, 1'b1);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    logic [37:0] e;
    int          ec;
    bit          exp_busy;
    if (rst_n && checking) begin
      exp_busy = (acc_cyc_q.size() > 0) && (cyc >= acc_cyc_q[0]) && (cyc < exp_cyc_q[0]);
      chk("busy", 64'(nif.busy), 64'(exp_busy));
      if (nif.done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 64'(nif.done), 64'd0);
        end else begin
          e  = exp_q.pop_front();
          ec = exp_cyc_q.pop_front();
          void'(acc_cyc_q.pop_front());
          chk("out", 64'(nif.out), 64'(e[31:0]));
          chk("sh", 64'(nif.sh), 64'(e[36:32]));
          chk("zero", 64'(nif.zero), 64'(e[37]));
          chk("done_cycle", 64'(cyc), 64'(ec));
        end
      end else if (exp_cyc_q.size() > 0 && cyc >= exp_cyc_q[0]) begin
        chk("missing_done", 64'(nif.done), 64'd1);
        void'(exp_q.pop_front());
        void'(exp_cyc_q.pop_front());
        void'(acc_cyc_q.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    bad++;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    logic        m;
    logic [31:0] v;
    rst_n     = 1'b0;
    nif.start = 1'b0;
    nif.mode  = 1'b0;
    nif.in    = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(nif.busy), 64'd0);
    chk("rst_done", 64'(nif.done), 64'd0);
    chk("rst_out", 64'(nif.out), 64'd0);
    chk("rst_sh", 64'(nif.sh), 64'd0);
    chk("rst_zero", 64'(nif.zero), 64'd0);
    chk("rst_state", 64'(state_dbg), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    free_cyc = cyc;
    checking = 1'b1;

    // directed cases
    op(1'b0, 32'h0000_0001, 1);
    op(1'b0, 32'h8000_0000, 1);
    op(1'b1, 32'h4000_0000, 1);
    op(1'b1, 32'hFFFF_FFF0, 1);
    op(1'b1, 32'h0000_0003, 1);
    op(1'b1, 32'hFFFF_FFFF, 1);
    op(1'b0, 32'h0000_0000, 1);
    op(1'b1, 32'h0000_0000, 1);
    op(1'b1, 32'h8000_0000, 1);
    // back-to-back: start on the DONE cycle
    op(1'b0, 32'h00F0_0000, 1);
    op(1'b0, 32'h00F0_0000, 0);
    op(1'b0, 32'h00F0_0000, 0);
    // ignored start while busy
    op(1'b0, 32'h0000_0001, 2);
    issue(1'b0, 32'h8000_0000, 1'b0);
    @(negedge clk);
    issue(1'b1, 32'h4000_0000, 1'b0);

    // random operands with varied shift distances
    for (int i = 0; i < 60; i++) begin
      m = 1'($urandom_range(0, 1));
      v = $urandom;
      if ($urandom_range(0, 7) == 0)
        v = '0;
      else if (m)
        v = $signed(v) >>> $urandom_range(0, 31);
      else
        v = v >> $urandom_range(0, 31);
      op(m, v, $urandom_range(0, 2));
    end

    // reset mid-operation aborts with no done
    op(1'b0, 32'h0000_0001, 1);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(nif.busy), 64'd0);
    chk("abort_done", 64'(nif.done), 64'd0);
    chk("abort_out", 64'(nif.out), 64'd0);
    chk("abort_sh", 64'(nif.sh), 64'd0);
    chk("abort_zero", 64'(nif.zero), 64'd0);
    chk("abort_state", 64'(state_dbg), 64'd0);
    exp_q.delete();
    acc_cyc_q.delete();
    exp_cyc_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    free_cyc = cyc;
    op(1'b1, 32'hFFFF_FFF0, 0);
    op(1'b0, 32'h0001_0000, 0);

    wait_free(3);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
